bp_cce_uc_responder: RTL and testbench
======================================

# bp_cce_uc_responder

CCE-side responder that terminates the LCE coherence interface for uncached traffic. It accepts uncached load and store requests from an LCE, issues them to a single memory command/response port, and returns uncached-data or store-done commands to the requesting LCE. It also sinks LCE responses. It is the far end of the lce_req / lce_resp / lce_cmd channels that the core's icache and dcache LCEs drive, and serves as a lightweight stand-in for a full CCE in uncached-only and bring-up configurations.

## Interface
- paddr_width_p, 40, physical address width
- lce_id_width_p, 4, LCE id width
- data_width_p, 64, payload width; fixed at 64
- lce_req layout, LSB first: msg_type[1:0], addr[paddr-1:0], lce_id, size[2:0], data[63:0]. Width is 2+paddr+lce_id+3+64 = 113 at defaults.
- lce_cmd layout: same field order as lce_req, with lce_id meaning destination. Same width.
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- lce_req_i  in  req_w  request message
- lce_req_v_i  in  1  request valid; ready-then-valid
- lce_req_ready_then_o  out  1  request ready
- lce_resp_i  in  req_w  LCE response; contents ignored
- lce_resp_v_i  in  1  response valid
- lce_resp_ready_then_o  out  1  response ready; constant 1 outside reset
- lce_cmd_o  out  req_w  command message
- lce_cmd_v_o  out  1  command valid
- lce_cmd_yumi_i  in  1  command consumed
- mem_cmd_addr_o  out  paddr  memory address
- mem_cmd_w_o  out  1  1 = store
- mem_cmd_size_o  out  3  log2 of bytes
- mem_cmd_data_o  out  64  store data
- mem_cmd_v_o  out  1  command valid
- mem_cmd_ready_and_i  in  1  memory ready; valid-ready
- mem_resp_data_i  in  64  aligned dword, load data
- mem_resp_v_i  in  1  memory response valid
- mem_resp_yumi_o  out  1  memory response consumed
- resp_count_o  out  8  count of LCE responses, wrapping
- error_o  out  1  one-cycle pulse on an illegal request

## Operation
- Request msg_type encodings:
  - e_uc_rd = 0, e_uc_wr = 1.
  - Types 2 and 3 (cached rd/wr) are illegal. They are accepted and dropped, and error_o pulses the following cycle.
- Command msg_type encodings: e_uc_data = 0, e_uc_st_done = 1.
- The FSM has four states: e_ready, e_mem_cmd, e_mem_resp, e_lce_cmd.
  - e_ready: lce_req_ready_then_o = 1. When lce_req_v_i is high, the request is latched into a holding register. A legal request moves to e_mem_cmd; an illegal one stays in e_ready.
  - e_mem_cmd: mem_cmd_v_o = 1, driven from the holding register. On mem_cmd_ready_and_i, move to e_mem_resp.
  - e_mem_resp: mem_resp_yumi_o = mem_resp_v_i, combinational. On that handshake, latch the command data and move to e_lce_cmd.
  - e_lce_cmd: lce_cmd_v_o = 1. On lce_cmd_yumi_i, move to e_ready.
- Load data formatting:
  - Take the 2^size byte lane at addr[2:0] & ~(2^size-1). Low address bits below the size alignment are ignored.
  - Replicate that lane across all 64 bits. For example, size 0 with byte 0xAB gives 0xABAB_ABAB_ABAB_ABAB.
  - Sizes above 3 are treated as size 3.
- Stores: data passes to memory unmodified (the LCE has already replicated it). The store-done command carries data = 0.
- Command fields: addr, size, and lce_id are copied from the request.
- Only one transaction is in flight at a time. There is no reordering.
- LCE responses are always accepted. resp_count_o increments by 1 per lce_resp_v_i and wraps from 255 to 0.

## Timing
- Reset values:
  - FSM state: e_ready.
  - All valid outputs, mem_resp_yumi_o, error_o, and resp_count_o: 0.
  - lce_req_ready_then_o and lce_resp_ready_then_o: 0 while reset_i is high.
- Reset asserted mid-transaction aborts it immediately (asynchronously). No command is issued afterwards.
- Latency, with a request accepted in cycle N:
  - mem_cmd_v_o rises at N+1.
  - With zero-wait memory (ready in N+1, resp_v in N+2), lce_cmd_v_o rises at N+3.
- All outputs except mem_resp_yumi_o are registered or state-decoded. mem_resp_yumi_o is the only combinational input-to-output path.
- lce_req_ready_then_o is low in every state except e_ready, so a request can never be lost.
- lce_cmd_o and mem_cmd_* hold stable while their valid is high and not yet handshaken.
- mem_resp_v_i outside e_mem_resp is ignored and not consumed.

## Structure
- Shared package bp_cce_uc_pkg holds:
  - the request and command type enums;
  - the message struct declaration macro, parameterized by paddr_width_p and lce_id_width_p;
  - the FSM state enum.
- One sub-module, bp_cce_uc_data_fmt: a combinational lane select and replicate from (data, addr[2:0], size), producing a 64-bit result.
- The holding register, FSM, and response counter live in the top module.

## Test plan
- Uncached load with size 2, addr 0x8000_0004, lce_id 3; memory returns 0x1122_3344_5566_7788. Required: lce_cmd e_uc_data, dst 3, data 0x1122_3344_1122_3344, lce_cmd_v_o at N+3.
- Uncached store with size 3, addr 0x8000_0010, data 0xDEAD_BEEF_CAFE_F00D. Required: mem_cmd_w_o = 1 with that data; e_uc_st_done to the source LCE, data 0.
- Backpressure: mem_cmd_ready_and_i held low for 5 cycles, then lce_cmd_yumi_i held low for 4 cycles. Required: outputs stay stable, lce_req_ready_then_o stays 0, and exactly one command is issued.
- Illegal request with msg_type 2. Required: error_o = 1 for one cycle, no mem_cmd, FSM stays in e_ready, and the next legal request is served.
- 300 LCE responses arriving during a pending load. Required: resp_count_o = 44 and the load completes correctly.
- reset_i asserted while in e_mem_resp. Required: all valids go to 0 immediately; after release, a late mem_resp_v_i is not consumed and no lce_cmd is issued.

Source files
------------

// File: rtl/bp_cce_uc_pkg.sv
// Shared types for the uncached CCE responder: message enums, the
// width-parameterized message struct macro and the responder FSM states.
`ifndef BP_CCE_UC_PKG_SV
`define BP_CCE_UC_PKG_SV

// Packed LSB first: msg_type, addr, lce_id, size, data.
`define DECLARE_BP_CCE_UC_MSG_S(paddr_w, lce_id_w) \
    typedef struct packed {                         \
        logic [63:0]         data;                  \
        logic [2:0]          size;                  \
        logic [lce_id_w-1:0] lce_id;                \
        logic [paddr_w-1:0]  addr;                  \
        logic [1:0]          msg_type;              \
    } bp_cce_uc_msg_s

package bp_cce_uc_pkg;

    typedef enum logic [1:0] {
        e_uc_rd     = 2'd0,
        e_uc_wr     = 2'd1,
        e_cached_rd = 2'd2,
        e_cached_wr = 2'd3
    } bp_cce_uc_req_type_e;

    typedef enum logic [1:0] {
        e_uc_data    = 2'd0,
        e_uc_st_done = 2'd1
    } bp_cce_uc_cmd_type_e;

    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_mem_cmd  = 2'd1,
        e_mem_resp = 2'd2,
        e_lce_cmd  = 2'd3
    } bp_cce_uc_state_e;

    // Only the two uncached request types are served.
    function automatic logic req_is_legal(input logic [1:0] msg_type);
        return (msg_type == e_uc_rd) || (msg_type == e_uc_wr);
    endfunction

endpackage

`endif

// File: rtl/bp_cce_uc_data_fmt.sv
// Load data formatter: selects the size-aligned byte lane addressed by
// addr[2:0] and replicates it across the 64-bit result.
module bp_cce_uc_data_fmt (
    input  logic [63:0] data_i,
    input  logic [2:0]  addr_i,
    input  logic [2:0]  size_i,
    output logic [63:0] data_o
);

    logic [2:0]  lane_off;
    logic [63:0] shifted;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lane_off = 3'd0;
        data_o   = data_i;

        // Address bits below the access size are dropped; sizes above 3 act as a full dword.
        case (size_i)
            3'd0:    lane_off = addr_i;
            3'd1:    lane_off = {addr_i[2:1], 1'b0};
            3'd2:    lane_off = {addr_i[2], 2'b00};
            default: lane_off = 3'd0;
        endcase

        shifted = data_i >> {lane_off, 3'b000};

        case (size_i)
            3'd0:    data_o = {8{shifted[7:0]}};
            3'd1:    data_o = {4{shifted[15:0]}};
            3'd2:    data_o = {2{shifted[31:0]}};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/bp_cce_uc_responder.sv
// Uncached-only CCE responder: serves one LCE uncached load/store at a time
// through a single memory port and answers with uc_data / uc_st_done commands.
module bp_cce_uc_responder
    import bp_cce_uc_pkg::*;
#(
    parameter int paddr_width_p  = 40,
    parameter int lce_id_width_p = 4,
    parameter int data_width_p   = 64,
    localparam int msg_width_lp  = 2 + paddr_width_p + lce_id_width_p + 3 + data_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic [msg_width_lp-1:0]  lce_req_i,
    input  logic                     lce_req_v_i,
    output logic                     lce_req_ready_then_o,

    input  logic [msg_width_lp-1:0]  lce_resp_i,
    input  logic                     lce_resp_v_i,
    output logic                     lce_resp_ready_then_o,

    output logic [msg_width_lp-1:0]  lce_cmd_o,
    output logic                     lce_cmd_v_o,
    input  logic                     lce_cmd_yumi_i,

    output logic [paddr_width_p-1:0] mem_cmd_addr_o,
    output logic                     mem_cmd_w_o,
    output logic [2:0]               mem_cmd_size_o,
    output logic [data_width_p-1:0]  mem_cmd_data_o,
    output logic                     mem_cmd_v_o,
    input  logic                     mem_cmd_ready_and_i,

    input  logic [data_width_p-1:0]  mem_resp_data_i,
    input  logic                     mem_resp_v_i,
    output logic                     mem_resp_yumi_o,

    output logic [7:0]               resp_count_o,
    output logic                     error_o
);

    `DECLARE_BP_CCE_UC_MSG_S(paddr_width_p, lce_id_width_p);

    bp_cce_uc_msg_s   req_cast, hold_r, cmd_cast;
    bp_cce_uc_state_e state_r, state_n;
    logic             out_of_reset_r;
    logic             req_accept;
    logic             hold_is_wr;
    logic [63:0]      fmt_data;
    logic [63:0]      cmd_data_r;
    logic             unused_lce_resp;

    assign req_cast   = lce_req_i;
    assign req_accept = lce_req_ready_then_o & lce_req_v_i;
    assign hold_is_wr = (hold_r.msg_type == e_uc_wr);

    // Response contents carry nothing this responder needs.
    assign unused_lce_resp = ^lce_resp_i;

    // Registered flag keeps both ready outputs low in reset without a reset-to-output path.
    assign lce_req_ready_then_o  = out_of_reset_r & (state_r == e_ready);
    assign lce_resp_ready_then_o = out_of_reset_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_r        <= e_ready;
            out_of_reset_r <= 1'b0;
            error_o        <= 1'b0;
            resp_count_o   <= 8'd0;
        end else begin
            state_r        <= state_n;
            out_of_reset_r <= 1'b1;
            error_o        <= req_accept & ~req_is_legal(req_cast.msg_type);
            if (lce_resp_v_i & lce_resp_ready_then_o)
                resp_count_o <= resp_count_o + 8'd1;
        end
    end

    // NOTE: datapath holding registers are left unreset; they are only read in states reached after a load.
    always_ff @(posedge clk_i) begin
        if (req_accept)
            hold_r <= req_cast;
        if (mem_resp_yumi_o)
            cmd_data_r <= hold_is_wr ? 64'd0 : fmt_data;
    end

    bp_cce_uc_data_fmt data_fmt (
        .data_i (mem_resp_data_i),
        .addr_i (hold_r.addr[2:0]),
        .size_i (hold_r.size),
        .data_o (fmt_data)
    );

    always_comb begin
        state_n         = state_r;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;

        case (state_r)
            e_ready: begin
                if (req_accept && req_is_legal(req_cast.msg_type))
                    state_n = e_mem_cmd;
            end
            e_mem_cmd: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_and_i)
                    state_n = e_mem_resp;
            end
            e_mem_resp: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i)
                    state_n = e_lce_cmd;
            end
            e_lce_cmd: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_yumi_i)
                    state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    assign mem_cmd_addr_o = hold_r.addr;
    assign mem_cmd_w_o    = hold_is_wr;
    assign mem_cmd_size_o = hold_r.size;
    assign mem_cmd_data_o = hold_r.data;

    always_comb begin
        cmd_cast          = hold_r;
        cmd_cast.msg_type = hold_is_wr ? e_uc_st_done : e_uc_data;
        cmd_cast.data     = cmd_data_r;
    end

    assign lce_cmd_o = cmd_cast;

endmodule

// File: tb/tb_bp_cce_uc_responder.sv
// Self-checking bench for bp_cce_uc_responder: directed protocol scenarios plus
// randomized uncached loads/stores checked against a lane-replication model.
module tb_bp_cce_uc_responder;

    localparam int PADDR = 40;
    localparam int IDW   = 4;
    localparam int MSGW  = 2 + PADDR + IDW + 3 + 64;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [MSGW-1:0]  lce_req_i;
    logic             lce_req_v_i;
    logic             lce_req_ready_then_o;
    logic [MSGW-1:0]  lce_resp_i;
    logic             lce_resp_v_i;
    logic             lce_resp_ready_then_o;
    logic [MSGW-1:0]  lce_cmd_o;
    logic             lce_cmd_v_o;
    logic             lce_cmd_yumi_i;
    logic [PADDR-1:0] mem_cmd_addr_o;
    logic             mem_cmd_w_o;
    logic [2:0]       mem_cmd_size_o;
    logic [63:0]      mem_cmd_data_o;
    logic             mem_cmd_v_o;
    logic             mem_cmd_ready_and_i;
    logic [63:0]      mem_resp_data_i;
    logic             mem_resp_v_i;
    logic             mem_resp_yumi_o;
    logic [7:0]       resp_count_o;
    logic             error_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_cmd = 0;
    int n_mem = 0;

    bp_cce_uc_responder dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .lce_req_i             (lce_req_i),
        .lce_req_v_i           (lce_req_v_i),
        .lce_req_ready_then_o  (lce_req_ready_then_o),
        .lce_resp_i            (lce_resp_i),
        .lce_resp_v_i          (lce_resp_v_i),
        .lce_resp_ready_then_o (lce_resp_ready_then_o),
        .lce_cmd_o             (lce_cmd_o),
        .lce_cmd_v_o           (lce_cmd_v_o),
        .lce_cmd_yumi_i        (lce_cmd_yumi_i),
        .mem_cmd_addr_o        (mem_cmd_addr_o),
        .mem_cmd_w_o           (mem_cmd_w_o),
        .mem_cmd_size_o        (mem_cmd_size_o),
        .mem_cmd_data_o        (mem_cmd_data_o),
        .mem_cmd_v_o           (mem_cmd_v_o),
        .mem_cmd_ready_and_i   (mem_cmd_ready_and_i),
        .mem_resp_data_i       (mem_resp_data_i),
        .mem_resp_v_i          (mem_resp_v_i),
        .mem_resp_yumi_o       (mem_resp_yumi_o),
        .resp_count_o          (resp_count_o),
        .error_o               (error_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lce_cmd_v_o && lce_cmd_yumi_i) n_cmd <= n_cmd + 1;
        if (mem_cmd_v_o && mem_cmd_ready_and_i) n_mem <= n_mem + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MSGW-1:0] make_msg(input logic [1:0] t, input logic [PADDR-1:0] a,
                                                 input logic [IDW-1:0] id, input logic [2:0] sz,
                                                 input logic [63:0] d);
        return {d, sz, id, a, t};
    endfunction

    // Reference: byte i of the result is byte (offset + i mod lane_bytes) of the memory dword.
    function automatic logic [63:0] exp_load(input logic [63:0] d, input logic [2:0] a, input logic [2:0] sz);
        int s;
        int n;
        int off;
        logic [63:0] r;
        s   = (sz > 3) ? 3 : int'(sz);
        n   = 1 << s;
        off = (int'(a) / n) * n;
        for (int i = 0; i < 8; i++)
            r[8*i +: 8] = d[8*(off + (i % n)) +: 8];
        return r;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 10 && !lce_req_ready_then_o; i++) step();
        check("req_ready_idle", lce_req_ready_then_o, 1'b1);
    endtask

    task automatic send_req(input logic [MSGW-1:0] msg, output int n0);
        wait_ready();
        lce_req_i   = msg;
        lce_req_v_i = 1'b1;
        n0 = cyc;
        step();
        lce_req_v_i = 1'b0;
        lce_req_i   = '0;
    endtask

    task automatic mem_cmd_phase(input int wait_cyc, input logic [PADDR-1:0] a, input logic w,
                                 input logic [2:0] sz, input logic [63:0] d);
        for (int i = 0; i < wait_cyc; i++) begin
            check("mem_cmd_v_held", mem_cmd_v_o, 1'b1);
            check("mem_cmd_addr_held", mem_cmd_addr_o, a);
            check("req_ready_busy", lce_req_ready_then_o, 1'b0);
            step();
        end
        check("mem_cmd_v", mem_cmd_v_o, 1'b1);
        check("mem_cmd_addr", mem_cmd_addr_o, a);
        check("mem_cmd_w", mem_cmd_w_o, w);
        check("mem_cmd_size", mem_cmd_size_o, sz);
        if (w) check("mem_cmd_data", mem_cmd_data_o, d);
        mem_cmd_ready_and_i = 1'b1;
        step();
        mem_cmd_ready_and_i = 1'b0;
    endtask

    task automatic mem_resp_phase(input int wait_cyc, input logic [63:0] d);
        for (int i = 0; i < wait_cyc; i++) begin
            check("mem_yumi_idle", mem_resp_yumi_o, 1'b0);
            step();
        end
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = d;
        #1;
        check("mem_resp_yumi", mem_resp_yumi_o, 1'b1);
        step();
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = $urandom();
    endtask

    task automatic lce_cmd_phase(input int wait_cyc, input logic [MSGW-1:0] exp_cmd,
                                 input int n0, input int exp_lat);
        check("lce_cmd_latency", cyc - n0, exp_lat);
        for (int i = 0; i < wait_cyc; i++) begin
            check("lce_cmd_v_held", lce_cmd_v_o, 1'b1);
            check("lce_cmd_held", lce_cmd_o, exp_cmd);
            check("req_ready_busy", lce_req_ready_then_o, 1'b0);
            step();
        end
        check("lce_cmd_v", lce_cmd_v_o, 1'b1);
        check("lce_cmd", lce_cmd_o, exp_cmd);
        lce_cmd_yumi_i = 1'b1;
        step();
        lce_cmd_yumi_i = 1'b0;
        check("lce_cmd_v_drop", lce_cmd_v_o, 1'b0);
    endtask

    // Full transaction; the expected command is derived from the model only.
    task automatic run_txn(input logic [1:0] t, input logic [PADDR-1:0] a, input logic [IDW-1:0] id,
                           input logic [2:0] sz, input logic [63:0] wd, input logic [63:0] md,
                           input int mw, input int rw, input int cw);
        int n0;
        int cmd0;
        logic [MSGW-1:0] exp_cmd;
        cmd0 = n_cmd;
        if (t == 2'd1) exp_cmd = make_msg(2'd1, a, id, sz, 64'd0);
        else           exp_cmd = make_msg(2'd0, a, id, sz, exp_load(md, a[2:0], sz));
        send_req(make_msg(t, a, id, sz, wd), n0);
        mem_cmd_phase(mw, a, t == 2'd1, sz, wd);
        mem_resp_phase(rw, md);
        lce_cmd_phase(cw, exp_cmd, n0, 3 + mw + rw);
        check("one_cmd_per_txn", n_cmd - cmd0, 1);
    endtask

    initial begin
        int n0;
        int mem0;
        int cmd0;
        logic [1:0]       rt;
        logic [PADDR-1:0] ra;
        logic [63:0]      rd;
        logic [63:0]      rm;

        reset_i             = 1'b1;
        lce_req_i           = '0;
        lce_req_v_i         = 1'b0;
        lce_resp_i          = '0;
        lce_resp_v_i        = 1'b0;
        lce_cmd_yumi_i      = 1'b0;
        mem_cmd_ready_and_i = 1'b0;
        mem_resp_data_i     = '0;
        mem_resp_v_i        = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req_ready", lce_req_ready_then_o, 1'b0);
        check("rst_resp_ready", lce_resp_ready_then_o, 1'b0);
        check("rst_mem_cmd_v", mem_cmd_v_o, 1'b0);
        check("rst_lce_cmd_v", lce_cmd_v_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_resp_count", resp_count_o, 8'd0);
        reset_i = 1'b0;
        step();
        check("resp_ready_run", lce_resp_ready_then_o, 1'b1);

        // Directed load: size 2 at 0x8000_0004
        run_txn(2'd0, 40'h80_0000_0004, 4'd3, 3'd2, 64'd0, 64'h1122_3344_5566_7788, 0, 0, 0);
        check("model_load_example", exp_load(64'h1122_3344_5566_7788, 3'd4, 3'd2), 64'h1122_3344_1122_3344);
        check("model_byte_example", exp_load(64'h0000_0000_0000_00AB, 3'd0, 3'd0), 64'hABAB_ABAB_ABAB_ABAB);

        // Directed store: size 3
        run_txn(2'd1, 40'h80_0000_0010, 4'd5, 3'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 0, 0, 0);

        // Backpressure on both memory command and LCE command
        run_txn(2'd0, 40'h80_0000_0023, 4'd9, 3'd0, 64'd0, 64'hF0E1_D2C3_B4A5_9687, 5, 0, 4);

        // Illegal request is dropped with a one-cycle error pulse
        mem0 = n_mem;
        cmd0 = n_cmd;
        wait_ready();
        lce_req_i   = make_msg(2'd2, 40'h80_0000_0040, 4'd1, 3'd3, 64'h55);
        lce_req_v_i = 1'b1;
        step();
        lce_req_v_i = 1'b0;
        check("illegal_error_pulse", error_o, 1'b1);
        check("illegal_no_mem_cmd", mem_cmd_v_o, 1'b0);
        check("illegal_stay_ready", lce_req_ready_then_o, 1'b1);
        step();
        check("illegal_error_clear", error_o, 1'b0);
        check("illegal_no_mem_hs", n_mem - mem0, 0);
        check("illegal_no_cmd", n_cmd - cmd0, 0);
        run_txn(2'd0, 40'h80_0000_0046, 4'd1, 3'd1, 64'd0, 64'h8899_AABB_CCDD_EEFF, 0, 0, 0);

        // Randomized loads and stores with random handshake stalls
        for (int k = 0; k < 24; k++) begin
            rt = 2'($urandom_range(0, 1));
            ra = {8'h80, $urandom()};
            rd = {$urandom(), $urandom()};
            rm = {$urandom(), $urandom()};
            run_txn(rt, ra, 4'($urandom()), 3'($urandom_range(0, 7)), rd, rm,
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while waiting on the memory response
        cmd0 = n_cmd;
        send_req(make_msg(2'd0, 40'h80_0000_0008, 4'd2, 3'd3, 64'd0), n0);
        mem_cmd_phase(0, 40'h80_0000_0008, 1'b0, 3'd3, 64'd0);
        #2;
        reset_i      = 1'b1;
        mem_resp_v_i = 1'b1;
        #1;
        check("rst_abort_yumi", mem_resp_yumi_o, 1'b0);
        check("rst_abort_mem_cmd_v", mem_cmd_v_o, 1'b0);
        check("rst_abort_lce_cmd_v", lce_cmd_v_o, 1'b0);
        check("rst_abort_req_ready", lce_req_ready_then_o, 1'b0);
        step();
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("late_resp_not_consumed", mem_resp_yumi_o, 1'b0);
            check("late_resp_no_cmd", lce_cmd_v_o, 1'b0);
        end
        mem_resp_v_i = 1'b0;
        check("rst_abort_no_cmd", n_cmd - cmd0, 0);
        check("rst_count_zero", resp_count_o, 8'd0);

        // 300 LCE responses during a pending load
        send_req(make_msg(2'd0, 40'h80_0000_0031, 4'd7, 3'd0, 64'd0), n0);
        lce_resp_v_i = 1'b1;
        lce_resp_i   = {$urandom(), $urandom()};
        repeat (300) @(posedge clk);
        #1;
        lce_resp_v_i = 1'b0;
        check("resp_count_wrap", resp_count_o, 8'd44);
        mem_cmd_phase(0, 40'h80_0000_0031, 1'b0, 3'd0, 64'd0);
        mem_resp_phase(0, 64'h0000_0000_0000_5A00);
        check("load_after_resps_v", lce_cmd_v_o, 1'b1);
        check("load_after_resps", lce_cmd_o,
              make_msg(2'd0, 40'h80_0000_0031, 4'd7, 3'd0, 64'h5A5A_5A5A_5A5A_5A5A));
        lce_cmd_yumi_i = 1'b1;
        step();
        lce_cmd_yumi_i = 1'b0;
        check("final_ready", lce_req_ready_then_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
